// File: rtl/cus19_crypto_pkg.sv
// Shared types, constants and rotate helpers for the cus19 cipher engine.
package cus19_crypto_pkg;

   localparam int DATA_W    = 8;
   localparam int RES_PAD_W = 8;
   localparam int CNT_W     = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_SRC = 3'd1,
      ST_RD_KEY = 3'd2,
      ST_LD_KEY = 3'd3,
      ST_ROUND  = 3'd4,
      ST_WRITE  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Rotate via a doubled word so the wrapped-out bits land back in the kept half.
   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                              input logic [CNT_W-1:0]  n);
      logic [2*DATA_W-1:0] w;
      w = {x, x} << n;
      return w[2*DATA_W-1:DATA_W];
   endfunction

   function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                              input logic [CNT_W-1:0]  n);
      logic [2*DATA_W-1:0] w;
      w = {x, x} >> n;
      return w[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/cus19_crypto_round.sv
// One cipher round; DEC is the exact inverse of ENC for the same round key.
module cus19_crypto_round
   import cus19_crypto_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   input  logic [DATA_W-1:0] k_i,
   input  logic              enc,
   output logic [DATA_W-1:0] d_next
);

   always_comb begin
      if (enc) begin
         d_next = rotl(d ^ k_i, CNT_W'(1));
      end else begin
         d_next = rotr(d, CNT_W'(1)) ^ k_i;
      end
   end

endmodule

// File: rtl/cus19_crypto_engine.sv
// Multi-cycle in-place byte cipher: reads data and key from data memory,
// runs the rounds, writes the result back to the data address.
//
// state     | meaning
// IDLE      | waiting for start; address and strobes at 0
// RD_SRC    | read strobe on data address
// RD_KEY    | capture data byte; read strobe on key address
// LD_KEY    | capture key byte; preset round counter by direction
// ROUND     | one round per cycle until the last round index
// WRITE     | single-cycle write of the result to the data address
// DONE      | done pulse with result presented; busy drops on exit
module cus19_crypto_engine
   import cus19_crypto_pkg::*;
#(
   parameter int Data_Width = DATA_W,
   parameter int Addr_Width = 8,
   parameter int Rounds     = 4
) (
   input  logic                    cus19_clk_in,
   input  logic                    cus19_rst_in,
   input  logic                    crypto_start_in,
   input  logic                    crypto_enc_in,
   input  logic [Addr_Width-1:0]   crypto_src_addr_in,
   input  logic [Addr_Width-1:0]   crypto_key_addr_in,
   output logic [Addr_Width-1:0]   mem_addr_out,
   output logic                    mem_rd_en_out,
   input  logic [Data_Width-1:0]   mem_rd_data_in,
   output logic                    mem_wr_en_out,
   output logic [Data_Width-1:0]   mem_wr_data_out,
   output logic                    crypto_busy_out,
   output logic                    crypto_done_out,
   output logic [2*Data_Width-1:0] crypto_result_out
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(Rounds - 1);

   state_t                state;
   logic [Addr_Width-1:0] src_reg;
   logic [Addr_Width-1:0] key_reg;
   logic                  enc_reg;
   logic [Data_Width-1:0] d_reg;
   logic [Data_Width-1:0] k_reg;
   logic [CNT_W-1:0]      rnd;
   logic [Data_Width-1:0] k_i;
   logic [Data_Width-1:0] d_next;
   logic                  last_round;

   assign k_i        = rotl(k_reg, rnd);
   // ENC counts up from 0, DEC counts down from the top; neither wraps.
   assign last_round = enc_reg ? (rnd == LAST_IDX) : (rnd == '0);

   cus19_crypto_round u_round (
      .d      (d_reg),
      .k_i    (k_i),
      .enc    (enc_reg),
      .d_next (d_next)
   );

   always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
      if (!cus19_rst_in) begin
         state             <= ST_IDLE;
         src_reg           <= '0;
         key_reg           <= '0;
         enc_reg           <= 1'b0;
         d_reg             <= '0;
         k_reg             <= '0;
         rnd               <= '0;
         mem_addr_out      <= '0;
         mem_rd_en_out     <= 1'b0;
         mem_wr_en_out     <= 1'b0;
         mem_wr_data_out   <= '0;
         crypto_busy_out   <= 1'b0;
         crypto_done_out   <= 1'b0;
         crypto_result_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (crypto_start_in) begin
                  src_reg         <= crypto_src_addr_in;
                  key_reg         <= crypto_key_addr_in;
                  enc_reg         <= crypto_enc_in;
                  crypto_busy_out <= 1'b1;
                  mem_addr_out    <= crypto_src_addr_in;
                  mem_rd_en_out   <= 1'b1;
                  state           <= ST_RD_SRC;
               end
            end
            ST_RD_SRC: begin
               mem_addr_out  <= key_reg;
               mem_rd_en_out <= 1'b1;
               state         <= ST_RD_KEY;
            end
            ST_RD_KEY: begin
               d_reg         <= mem_rd_data_in;
               mem_addr_out  <= '0;
               mem_rd_en_out <= 1'b0;
               state         <= ST_LD_KEY;
            end
            ST_LD_KEY: begin
               k_reg <= mem_rd_data_in;
               rnd   <= crypto_enc_in_sel(enc_reg);
               state <= ST_ROUND;
            end
            ST_ROUND: begin
               d_reg <= d_next;
               if (last_round) begin
                  mem_addr_out    <= src_reg;
                  mem_wr_en_out   <= 1'b1;
                  mem_wr_data_out <= d_next;
                  state           <= ST_WRITE;
               end else if (enc_reg) begin
                  rnd <= rnd + CNT_W'(1);
               end else begin
                  rnd <= rnd - CNT_W'(1);
               end
            end
            ST_WRITE: begin
               mem_addr_out      <= '0;
               mem_wr_en_out     <= 1'b0;
               mem_wr_data_out   <= '0;
               crypto_result_out <= {RES_PAD_W'(0), d_reg};
               crypto_done_out   <= 1'b1;
               state             <= ST_DONE;
            end
            ST_DONE: begin
               crypto_done_out <= 1'b0;
               crypto_busy_out <= 1'b0;
               state           <= ST_IDLE;
            end
            default: begin
               mem_addr_out    <= '0;
               mem_rd_en_out   <= 1'b0;
               mem_wr_en_out   <= 1'b0;
               crypto_done_out <= 1'b0;
               crypto_busy_out <= 1'b0;
               state           <= ST_IDLE;
            end
         endcase
      end
   end

   function automatic logic [CNT_W-1:0] crypto_enc_in_sel(input logic enc);
      return enc ? '0 : LAST_IDX;
   endfunction

endmodule

// File: tb/tb_cus19_crypto_engine.sv
// Self-checking bench for cus19_crypto_engine with a behavioural memory and cipher model.
module tb_cus19_crypto_engine;

   localparam int ROUNDS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        enc = 1'b0;
   logic [7:0]  src = '0;
   logic [7:0]  key = '0;
   logic [7:0]  mem_addr;
   logic        rd_en;
   logic [7:0]  rd_data = '0;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;
   logic [15:0] result;

   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [7:0]  pl_data = '0;
   logic [7:0]  mem [256];

   int n_checks = 0;
   int n_fail = 0;
   int n_writes = 0;
   int excl_viol = 0;
   int idle_viol = 0;

   always #5 clk = ~clk;

   cus19_crypto_engine #(.Data_Width(8), .Addr_Width(8), .Rounds(ROUNDS)) dut (
      .cus19_clk_in       (clk),
      .cus19_rst_in       (rst_n),
      .crypto_start_in    (start),
      .crypto_enc_in      (enc),
      .crypto_src_addr_in (src),
      .crypto_key_addr_in (key),
      .mem_addr_out       (mem_addr),
      .mem_rd_en_out      (rd_en),
      .mem_rd_data_in     (rd_data),
      .mem_wr_en_out      (wr_en),
      .mem_wr_data_out    (wr_data),
      .crypto_busy_out    (busy),
      .crypto_done_out    (done),
      .crypto_result_out  (result)
   );

   // Synchronous-read data memory plus a bench-side preload port.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[mem_addr];
      if (wr_en) begin
         mem[mem_addr] <= wr_data;
         n_writes++;
      end
      if (pl_en) mem[pl_addr] <= pl_data;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_en && wr_en) excl_viol++;
         if (!busy && (mem_addr != 8'd0 || rd_en || wr_en)) idle_viol++;
      end
   end

   // Reference cipher from the round rules, in plain integer arithmetic.
   function automatic logic [7:0] ref_cipher(input logic [7:0] d, input logic [7:0] k, input bit e);
      int x, kk, ki;
      x = d;
      kk = k;
      if (e) begin
         for (int r = 0; r < ROUNDS; r++) begin
            ki = ((kk << r) | (kk >> (8 - r))) & 255;
            x = x ^ ki;
            x = ((x << 1) | (x >> 7)) & 255;
         end
      end else begin
         for (int r = ROUNDS - 1; r >= 0; r--) begin
            ki = ((kk << r) | (kk >> (8 - r))) & 255;
            x = (((x >> 1) | (x << 7)) & 255) ^ ki;
         end
      end
      return 8'(x);
   endfunction

   task automatic mem_set(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Latency counts clock edges from the one sampling start through the one raising done.
   task automatic run_op(input logic [7:0] s, input logic [7:0] k, input bit e, input bit extra,
                         output int lat, output logic [15:0] res);
      @(negedge clk);
      src = s; key = k; enc = e; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 start = 1'b0;
         lat++;
         if (extra && lat == 3 && done !== 1'b1) begin
            src = s ^ 8'h40; key = k ^ 8'h40; enc = ~e; start = 1'b1;
         end
      end
      res = result;
      n_checks++;
      if (lat != ROUNDS + 5) begin n_fail++; $display("FAIL done_latency: got %0d want %0d", lat, ROUNDS + 5); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during_done: got %b want 1", busy); end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL done_busy_drop: got done=%b busy=%b want 0 0", done, busy);
      end
      n_checks++;
      if (result !== res) begin n_fail++; $display("FAIL result_hold: got %h want %h", result, res); end
   endtask

   task automatic check_op(input string name, input logic [7:0] s, input logic [7:0] k, input bit e,
                           input logic [7:0] exp, input bit extra);
      int lat, w0;
      logic [15:0] res;
      w0 = n_writes;
      run_op(s, k, e, extra, lat, res);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (mem[s] !== exp) begin n_fail++; $display("FAIL %s_mem: got %h want %h", name, mem[s], exp); end
      n_checks++;
      if (res !== {8'h00, exp}) begin n_fail++; $display("FAIL %s_result: got %h want %h", name, res, {8'h00, exp}); end
      n_checks++;
      if (n_writes - w0 != 1) begin n_fail++; $display("FAIL %s_writes: got %0d want 1", name, n_writes - w0); end
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if ({busy, done, rd_en, wr_en} !== 4'b0 || mem_addr !== 8'h00 || wr_data !== 8'h00 || result !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h res=%h want all 0",
                  busy, done, rd_en, wr_en, mem_addr, wr_data, result);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_enc_dec_basic;
      mem_set(8'd3, 8'h0A);
      mem_set(8'd5, 8'h05);
      check_op("enc_basic", 8'd3, 8'd5, 1'b1, 8'hA0, 1'b0);
      check_op("dec_basic", 8'd3, 8'd5, 1'b0, 8'h0A, 1'b0);
   endtask

   task automatic test_rotate_path;
      mem_set(8'd10, 8'h81);
      mem_set(8'd11, 8'h00);
      check_op("rotate_path", 8'd10, 8'd11, 1'b1, 8'h18, 1'b0);
   endtask

   task automatic test_start_while_busy;
      logic [7:0] exp;
      mem_set(8'd12, 8'h5A);
      mem_set(8'd13, 8'hC3);
      mem_set(8'd12 ^ 8'h40, 8'h77);
      exp = ref_cipher(8'h5A, 8'hC3, 1'b1);
      check_op("start_busy", 8'd12, 8'd13, 1'b1, exp, 1'b1);
      n_checks++;
      if (mem[8'd12 ^ 8'h40] !== 8'h77) begin
         n_fail++; $display("FAIL start_busy_other_mem: got %h want 77", mem[8'd12 ^ 8'h40]);
      end
   endtask

   task automatic test_reset_mid;
      int w0;
      logic [7:0] exp;
      mem_set(8'd20, 8'h55);
      mem_set(8'd21, 8'h33);
      w0 = n_writes;
      @(negedge clk);
      src = 8'd20; key = 8'd21; enc = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || result !== 16'h0 || mem_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b wr=%b res=%h addr=%h want 0",
                  busy, done, wr_en, result, mem_addr);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      n_checks++;
      if (n_writes != w0 || mem[20] !== 8'h55) begin
         n_fail++; $display("FAIL reset_mid_nowrite: got writes=%0d mem=%h want 0 55", n_writes - w0, mem[20]);
      end
      exp = ref_cipher(8'h55, 8'h33, 1'b1);
      check_op("after_reset", 8'd20, 8'd21, 1'b1, exp, 1'b0);
   endtask

   task automatic test_src_eq_key;
      logic [7:0] e1, e2;
      mem_set(8'd7, 8'h3C);
      e1 = ref_cipher(8'h3C, 8'h3C, 1'b1);
      check_op("same_enc", 8'd7, 8'd7, 1'b1, e1, 1'b0);
      e2 = ref_cipher(e1, e1, 1'b0);
      check_op("same_dec", 8'd7, 8'd7, 1'b0, e2, 1'b0);
   endtask

   task automatic test_random;
      logic [7:0] s, k, d, kv, kv2, e1, e2;
      bit e;
      for (int it = 0; it < 12; it++) begin
         s = 8'($urandom_range(32, 255));
         k = 8'($urandom_range(32, 255));
         d = 8'($urandom);
         kv = 8'($urandom);
         e = 1'($urandom);
         mem_set(k, kv);
         mem_set(s, d);
         if (s == k) kv = d;
         e1 = ref_cipher(d, kv, e);
         check_op("rand_fwd", s, k, e, e1, 1'b0);
         kv2 = (s == k) ? e1 : kv;
         e2 = ref_cipher(e1, kv2, ~e);
         check_op("rand_back", s, k, ~e, e2, 1'b0);
         if (s != k) begin
            n_checks++;
            if (mem[s] !== d) begin n_fail++; $display("FAIL rand_roundtrip: got %h want %h", mem[s], d); end
         end
      end
   endtask

   task automatic test_protocol;
      n_checks++;
      if (excl_viol != 0) begin n_fail++; $display("FAIL rd_wr_exclusive: got %0d violations want 0", excl_viol); end
      n_checks++;
      if (idle_viol != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d violations want 0", idle_viol); end
   endtask

   initial begin
      test_reset;
      test_enc_dec_basic;
      test_rotate_path;
      test_start_while_busy;
      test_reset_mid;
      test_src_eq_key;
      test_random;
      test_protocol;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
